p4_router_ipv4_chksum_extern: RTL and testbench
===============================================

Name: p4_router_ipv4_chksum_extern

Overview:
- Implements the two user externs of the FRR T1 ECP tiny-BCAM vitis_net_p4 instance: UserIPv4ChkVerify and UserIPv4ChkUpdate.
- Sits beside the P4 core and consumes its 192-bit user_extern_out / 2-bit valid bus.
- Returns the 17-bit user_extern_in / 2-bit valid bus after a fixed pipeline latency.
- Keeps saturating statistics counters for verify pass/fail and update events.

Parameters:
- LATENCY, 4, cycles from extern_out_valid to extern_in_valid; legal range 3..16, out-of-range is an elaboration error.
- CNT_WIDTH, 32, width of each statistics counter.

Ports:
- clk  input  1  core clock (AXIS clock domain of the P4 core, 200 MHz).
- rst_n  input  1  asynchronous, active-low reset.
- extern_out  input  192  USER_EXTERN_OUT_T. [159:0] is the IPV4_T header for verify; [191:160] is {hdr_chk, old_ttl, new_ttl} for update.
- extern_out_valid  input  2  USER_EXTERN_VALID_T. Bit0 = verify request, bit1 = update request.
- extern_in  output  17  USER_EXTERN_IN_T. Bit0 = verify result (1 = checksum good); [16:1] = updated header checksum.
- extern_in_valid  output  2  bit0 = verify result valid, bit1 = update result valid.
- cnt_clear  input  1  synchronous clear of all counters.
- verify_pass_cnt  output  CNT_WIDTH  count of verify results equal to 1.
- verify_fail_cnt  output  CNT_WIDTH  count of verify results equal to 0.
- update_cnt  output  CNT_WIDTH  count of update results returned.

Behaviour:
- Reset values: all outputs are 0, and all pipeline valid bits are 0. Data registers need not be reset.
- Interface rules:
  - No backpressure. The block accepts a request on every cycle.
  - The two lanes are fully independent. Both may be valid in the same cycle, and both results then emerge in the same output cycle.
  - Ordering is strictly preserved per lane.
- Latency: the result for a request sampled at cycle N appears with its valid at cycle N+LATENCY.
  - The core compute takes 3 register stages.
  - The remaining LATENCY-3 stages are a valid-plus-data delay line.
  - Output bits of a lane whose valid is 0 are don't-care; the bench masks them.
- Verify lane:
  - Form ten 16-bit words from the header in wire order: {version,hdr_len,tos}, length, id, {flags,offset}, {ttl,protocol}, hdr_chk, src[31:16], src[15:0], dst[31:16], dst[15:0].
  - S1: five pairwise 17-bit sums.
  - S2: 20-bit total.
  - S3: fold the carries twice into 16 bits (one's-complement sum).
  - Result = 1 iff the folded sum equals 16'hFFFF.
- Update lane (RFC 1624 eqn 3):
  - m = {old_ttl, 8'h00}, m' = {new_ttl, 8'h00}.
  - HC' = ~(~hdr_chk +' ~m +' m'), where +' is the end-around-carry add.
  - Registered across the same 3 stages.
  - new_ttl == old_ttl returns hdr_chk unchanged, including the 16'hFFFF and 16'h0000 inputs.
- Counters:
  - Increment on the output valid.
  - Both verify counters never increment in the same cycle; a single result hits exactly one of them.
  - Each counter saturates at all-ones and holds.
  - cnt_clear forces 0 and wins over a same-cycle increment; that event is not counted.
- Reset mid-operation: in-flight requests are discarded. No extern_in_valid is emitted for any request sampled before rst_n deasserts.
- Unknown or X on extern_out while its lane valid is low must not propagate to the valid outputs.

Test Plan:
1. Verify, good header: 4500 0073 0000 4000 4011 B861 C0A8 0001 C0A8 00C7, valid=01 at cycle N. Required: extern_in_valid=01 at N+4, extern_in[0]=1, verify_pass_cnt=1.
2. Verify, bad header: same header with hdr_chk=B862. Required: extern_in[0]=0, verify_fail_cnt=1, verify_pass_cnt unchanged.
3. Update: hdr_chk=B861, old_ttl=40, new_ttl=3F. Required: extern_in[16:1]=B961 at N+4, update_cnt=1. Also hdr_chk=FFFF, old=new=05 returns FFFF.
4. Simultaneous and back-to-back: valid=11 for 8 consecutive cycles with alternating good/bad headers. Required:
   - extern_in_valid=11 for 8 consecutive cycles starting at N+4.
   - Results alternate 1/0 in order.
   - pass=4, fail=4, update=8.
   - Repeat with LATENCY=3 and LATENCY=16: results at N+3 and N+16.
5. Counter boundaries:
   - Preload or force verify_pass_cnt to FFFFFFFE, then send 3 good verifies. Required: the count stays at FFFFFFFF.
   - Assert cnt_clear on the same cycle a result is valid. Required: the count reads 0 on the next cycle.
6. Reset mid-flight: issue valid=11 at cycle N, assert rst_n low at N+2 for 2 cycles. Required: extern_in_valid stays 00 through N+10, all counters are 0, and a request after reset works normally.

Source files
------------

// File: rtl/p4_router_ipv4_chksum_extern.sv
// -----------------------------------------------------------------------------
// p4_router_ipv4_chksum_extern
//
// User externs for the vitis_net_p4 core: IPv4 header checksum verify
// (UserIPv4ChkVerify) and RFC 1624 incremental checksum update after a TTL
// rewrite (UserIPv4ChkUpdate). Both lanes run through a 3-stage compute
// pipeline followed by a LATENCY-3 delay line, with no backpressure.
//
// Ports:
//   clk              core (AXIS) clock
//   rst_n            asynchronous active-low reset
//   extern_out       [159:0] IPv4 header (verify),
//                    [191:160] {hdr_chk, old_ttl, new_ttl} (update)
//   extern_out_valid bit0 verify request, bit1 update request
//   extern_in        bit0 verify result (1 = good), [16:1] updated checksum
//   extern_in_valid  bit0 verify result valid, bit1 update result valid
//   cnt_clear        synchronous clear of the statistics counters
//   verify_pass_cnt  saturating count of good verify results
//   verify_fail_cnt  saturating count of bad verify results
//   update_cnt       saturating count of update results
// -----------------------------------------------------------------------------
module p4_router_ipv4_chksum_extern #(
    parameter int LATENCY   = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [191:0]         extern_out,
    input  logic [1:0]           extern_out_valid,
    output logic [16:0]          extern_in,
    output logic [1:0]           extern_in_valid,
    input  logic                 cnt_clear,
    output logic [CNT_WIDTH-1:0] verify_pass_cnt,
    output logic [CNT_WIDTH-1:0] verify_fail_cnt,
    output logic [CNT_WIDTH-1:0] update_cnt
);

    localparam int DLY = LATENCY - 3;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    generate
        if (LATENCY < 3 || LATENCY > 16) begin : g_bad_latency
            $error("LATENCY must be in the range 3..16");
        end
    endgenerate

    // End-around-carry fold of a 17-bit sum into 16 bits; cannot overflow
    // again because the largest input (1FFFE) folds to FFFF.
    function automatic logic [15:0] fold17(input logic [16:0] x);
        return x[15:0] + {15'd0, x[16]};
    endfunction

    // Two folds bring the 20-bit total of ten words back to 16 bits.
    function automatic logic [15:0] fold20(input logic [19:0] t);
        logic [16:0] f1;
        f1 = {1'b0, t[15:0]} + {13'd0, t[19:16]};
        return fold17(f1);
    endfunction

    // Update-lane field extraction.
    logic [15:0] u_hc_s;
    logic [15:0] u_m_s;
    logic [15:0] u_mp_s;
    logic        u_same_s;
    assign u_hc_s   = extern_out[191:176];
    assign u_m_s    = {extern_out[175:168], 8'h00};
    assign u_mp_s   = {extern_out[167:160], 8'h00};
    assign u_same_s = (extern_out[175:168] == extern_out[167:160]);

    // Pipeline valids: only these are reset, so X data never reaches a valid.
    logic [1:0] valid_s1_r;
    logic [1:0] valid_s2_r;
    logic [1:0] valid_s3_r;

    // Valid shift through the three compute stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_s1_r <= 2'b00;
            valid_s2_r <= 2'b00;
            valid_s3_r <= 2'b00;
        end else begin
            valid_s1_r <= extern_out_valid;
            valid_s2_r <= valid_s1_r;
            valid_s3_r <= valid_s2_r;
        end
    end

    logic [16:0] v_pair_s1_r [5];
    logic [19:0] v_total_s2_r;
    logic        v_ok_s3_r;
    logic [16:0] u_sum_s1_r;
    logic [15:0] u_mp_s1_r;
    logic [15:0] u_hc_s1_r;
    logic        u_same_s1_r;
    logic [16:0] u_sum_s2_r;
    logic [15:0] u_hc_s2_r;
    logic        u_same_s2_r;
    logic [15:0] u_chk_s3_r;

    // Compute datapath for both lanes; data is qualified by the valid pipe.
    always_ff @(posedge clk) begin
        // S1: pairwise word sums (verify), ~HC +' ~m partial sum (update).
        for (int i = 0; i < 5; i++) begin
            v_pair_s1_r[i] <= {1'b0, extern_out[159-32*i -: 16]}
                            + {1'b0, extern_out[143-32*i -: 16]};
        end
        u_sum_s1_r  <= {1'b0, ~u_hc_s} + {1'b0, ~u_m_s};
        u_mp_s1_r   <= u_mp_s;
        u_hc_s1_r   <= u_hc_s;
        u_same_s1_r <= u_same_s;
        // S2: 20-bit total (verify), fold then add m' (update).
        v_total_s2_r <= {3'd0, v_pair_s1_r[0]} + {3'd0, v_pair_s1_r[1]}
                      + {3'd0, v_pair_s1_r[2]} + {3'd0, v_pair_s1_r[3]}
                      + {3'd0, v_pair_s1_r[4]};
        u_sum_s2_r  <= {1'b0, fold17(u_sum_s1_r)} + {1'b0, u_mp_s1_r};
        u_hc_s2_r   <= u_hc_s1_r;
        u_same_s2_r <= u_same_s1_r;
        // S3: final fold. An unchanged TTL bypasses the arithmetic because
        // the one's-complement path would map FFFF to 0000.
        v_ok_s3_r  <= (fold20(v_total_s2_r) == 16'hFFFF);
        u_chk_s3_r <= u_same_s2_r ? u_hc_s2_r : ~fold17(u_sum_s2_r);
    end

    logic [1:0]  out_v_s;
    logic [16:0] out_d_s;

    generate
        if (DLY == 0) begin : g_no_delay
            assign out_v_s = valid_s3_r;
            assign out_d_s = {u_chk_s3_r, v_ok_s3_r};
        end else begin : g_delay
            logic [1:0]  dl_v_r [DLY];
            logic [16:0] dl_d_r [DLY];

            // Delay-line valids, cleared by reset to drop in-flight requests.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DLY; i++) begin
                        dl_v_r[i] <= 2'b00;
                    end
                end else begin
                    dl_v_r[0] <= valid_s3_r;
                    for (int i = 1; i < DLY; i++) begin
                        dl_v_r[i] <= dl_v_r[i-1];
                    end
                end
            end

            // Delay-line data, qualified by dl_v_r.
            always_ff @(posedge clk) begin
                dl_d_r[0] <= {u_chk_s3_r, v_ok_s3_r};
                for (int i = 1; i < DLY; i++) begin
                    dl_d_r[i] <= dl_d_r[i-1];
                end
            end

            assign out_v_s = dl_v_r[DLY-1];
            assign out_d_s = dl_d_r[DLY-1];
        end
    endgenerate

    // Data bits of an idle lane are forced low so reset and idle read as 0.
    assign extern_in_valid = out_v_s;
    assign extern_in       = {out_d_s[16:1] & {16{out_v_s[1]}},
                              out_d_s[0] & out_v_s[0]};

    logic inc_pass_s;
    logic inc_fail_s;
    logic inc_upd_s;
    assign inc_pass_s = out_v_s[0] &  out_d_s[0];
    assign inc_fail_s = out_v_s[0] & ~out_d_s[0];
    assign inc_upd_s  = out_v_s[1];

    // Saturating statistics counters; clear takes priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            verify_pass_cnt <= '0;
            verify_fail_cnt <= '0;
            update_cnt      <= '0;
        end else if (cnt_clear) begin
            verify_pass_cnt <= '0;
            verify_fail_cnt <= '0;
            update_cnt      <= '0;
        end else begin
            if (inc_pass_s && verify_pass_cnt != CNT_MAX) begin
                verify_pass_cnt <= verify_pass_cnt + CNT_ONE;
            end else begin
                verify_pass_cnt <= verify_pass_cnt;
            end
            if (inc_fail_s && verify_fail_cnt != CNT_MAX) begin
                verify_fail_cnt <= verify_fail_cnt + CNT_ONE;
            end else begin
                verify_fail_cnt <= verify_fail_cnt;
            end
            if (inc_upd_s && update_cnt != CNT_MAX) begin
                update_cnt <= update_cnt + CNT_ONE;
            end else begin
                update_cnt <= update_cnt;
            end
        end
    end

endmodule

// File: tb/tb_p4_router_ipv4_chksum_extern.sv
// -----------------------------------------------------------------------------
// Testbench for p4_router_ipv4_chksum_extern. Three instances share the same
// stimulus: LATENCY=4/CNT_WIDTH=32 (main), LATENCY=3/CNT_WIDTH=3 (short
// pipeline, narrow counters for saturation) and LATENCY=16/CNT_WIDTH=32.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_p4_router_ipv4_chksum_extern;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cnt_clear = 1'b0;
    logic [191:0] extern_out = '0;
    logic [1:0]   extern_out_valid = 2'b00;

    logic [16:0] ei4, ei3, ei16;
    logic [1:0]  ev4, ev3, ev16;
    logic [31:0] p4, f4, u4, p16, f16, u16;
    logic [2:0]  p3, f3, u3;

    int checks = 0;
    int errors = 0;

    localparam logic [159:0] GOOD_HDR = 160'h4500_0073_0000_4000_4011_B861_C0A8_0001_C0A8_00C7;
    localparam logic [159:0] BAD_HDR  = 160'h4500_0073_0000_4000_4011_B862_C0A8_0001_C0A8_00C7;
    localparam logic [31:0]  UPD_A    = 32'hB861_403F;

    always #5 clk = ~clk;

    p4_router_ipv4_chksum_extern #(.LATENCY(4), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .extern_out(extern_out),
        .extern_out_valid(extern_out_valid), .extern_in(ei4),
        .extern_in_valid(ev4), .cnt_clear(cnt_clear),
        .verify_pass_cnt(p4), .verify_fail_cnt(f4), .update_cnt(u4));

    p4_router_ipv4_chksum_extern #(.LATENCY(3), .CNT_WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .extern_out(extern_out),
        .extern_out_valid(extern_out_valid), .extern_in(ei3),
        .extern_in_valid(ev3), .cnt_clear(cnt_clear),
        .verify_pass_cnt(p3), .verify_fail_cnt(f3), .update_cnt(u3));

    p4_router_ipv4_chksum_extern #(.LATENCY(16), .CNT_WIDTH(32)) dut16 (
        .clk(clk), .rst_n(rst_n), .extern_out(extern_out),
        .extern_out_valid(extern_out_valid), .extern_in(ei16),
        .extern_in_valid(ev16), .cnt_clear(cnt_clear),
        .verify_pass_cnt(p16), .verify_fail_cnt(f16), .update_cnt(u16));

    task automatic drive(input logic [1:0] v, input logic [191:0] d);
        extern_out_valid = v;
        extern_out       = d;
    endtask

    task automatic drive_idle();
        extern_out_valid = 2'b00;
        extern_out       = 'x;
    endtask

    task automatic idle(input int n);
        drive_idle();
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counters();
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk);
        checks++; if (ev4 !== 2'b00) begin errors++; $display("FAIL reset_valid got %b exp 00", ev4); end
        checks++; if (ei4 !== 17'h0) begin errors++; $display("FAIL reset_data got %h exp 0", ei4); end
        checks++; if (p4 !== 32'h0) begin errors++; $display("FAIL reset_pass got %h exp 0", p4); end
        checks++; if (f4 !== 32'h0) begin errors++; $display("FAIL reset_fail got %h exp 0", f4); end
        checks++; if (u4 !== 32'h0) begin errors++; $display("FAIL reset_upd got %h exp 0", u4); end
        checks++; if (ev3 !== 2'b00 || ev16 !== 2'b00) begin errors++; $display("FAIL reset_valid_other got %b %b exp 00", ev3, ev16); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_verify(input logic [159:0] hdr, input logic exp_ok,
                               input logic [31:0] exp_pass, input logic [31:0] exp_fail);
        drive(2'b01, {32'h0, hdr});
        @(negedge clk);
        drive_idle();
        for (int k = 1; k < 4; k++) begin
            checks++; if (ev4 !== 2'b00) begin errors++; $display("FAIL verify_early cyc %0d got %b exp 00", k, ev4); end
            @(negedge clk);
        end
        checks++; if (ev4 !== 2'b01) begin errors++; $display("FAIL verify_valid got %b exp 01", ev4); end
        checks++; if (ei4[0] !== exp_ok) begin errors++; $display("FAIL verify_result got %b exp %b", ei4[0], exp_ok); end
        @(negedge clk);
        checks++; if (p4 !== exp_pass) begin errors++; $display("FAIL verify_pass_cnt got %h exp %h", p4, exp_pass); end
        checks++; if (f4 !== exp_fail) begin errors++; $display("FAIL verify_fail_cnt got %h exp %h", f4, exp_fail); end
    endtask

    task automatic test_update();
        logic [31:0] vec [4];
        logic [15:0] exp [4];
        vec[0] = 32'hB861_403F; exp[0] = 16'hB961;
        vec[1] = 32'hFFFF_0505; exp[1] = 16'hFFFF;
        vec[2] = 32'h0000_0707; exp[2] = 16'h0000;
        vec[3] = 32'h1234_807F; exp[3] = 16'h1334;
        for (int i = 0; i < 4; i++) begin
            drive(2'b10, {vec[i], 160'h0});
            @(negedge clk);
        end
        drive_idle();
        for (int i = 0; i < 4; i++) begin
            checks++; if (ev4 !== 2'b10) begin errors++; $display("FAIL update_valid %0d got %b exp 10", i, ev4); end
            checks++; if (ei4[16:1] !== exp[i]) begin errors++; $display("FAIL update_chk %0d got %h exp %h", i, ei4[16:1], exp[i]); end
            @(negedge clk);
        end
        checks++; if (ev4 !== 2'b00) begin errors++; $display("FAIL update_tail_valid got %b exp 00", ev4); end
        checks++; if (u4 !== 32'd4) begin errors++; $display("FAIL update_cnt got %0d exp 4", u4); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] xv;
        logic [16:0] xd;
        idle(20);
        clear_counters();
        for (int t = 0; t < 28; t++) begin
            xv = (t >= 4 && t < 12) ? 2'b11 : 2'b00;
            xd = {16'hB961, ((t - 4) % 2 == 0)};
            checks++; if (ev4 !== xv) begin errors++; $display("FAIL b2b_l4_valid t %0d got %b exp %b", t, ev4, xv); end
            if (xv == 2'b11) begin
                checks++; if (ei4 !== xd) begin errors++; $display("FAIL b2b_l4_data t %0d got %h exp %h", t, ei4, xd); end
            end
            xv = (t >= 3 && t < 11) ? 2'b11 : 2'b00;
            xd = {16'hB961, ((t - 3) % 2 == 0)};
            checks++; if (ev3 !== xv) begin errors++; $display("FAIL b2b_l3_valid t %0d got %b exp %b", t, ev3, xv); end
            if (xv == 2'b11) begin
                checks++; if (ei3 !== xd) begin errors++; $display("FAIL b2b_l3_data t %0d got %h exp %h", t, ei3, xd); end
            end
            xv = (t >= 16 && t < 24) ? 2'b11 : 2'b00;
            xd = {16'hB961, ((t - 16) % 2 == 0)};
            checks++; if (ev16 !== xv) begin errors++; $display("FAIL b2b_l16_valid t %0d got %b exp %b", t, ev16, xv); end
            if (xv == 2'b11) begin
                checks++; if (ei16 !== xd) begin errors++; $display("FAIL b2b_l16_data t %0d got %h exp %h", t, ei16, xd); end
            end
            if (t < 8) drive(2'b11, {UPD_A, (t % 2 == 0) ? GOOD_HDR : BAD_HDR});
            else drive_idle();
            @(negedge clk);
        end
        checks++; if (p4 !== 32'd4 || f4 !== 32'd4 || u4 !== 32'd8) begin errors++; $display("FAIL b2b_l4_cnt got %0d %0d %0d exp 4 4 8", p4, f4, u4); end
        checks++; if (p16 !== 32'd4 || f16 !== 32'd4 || u16 !== 32'd8) begin errors++; $display("FAIL b2b_l16_cnt got %0d %0d %0d exp 4 4 8", p16, f16, u16); end
        checks++; if (p3 !== 3'd4 || f3 !== 3'd4 || u3 !== 3'd7) begin errors++; $display("FAIL b2b_l3_cnt got %0d %0d %0d exp 4 4 7", p3, f3, u3); end
    endtask

    task automatic test_cnt_clear();
        drive(2'b01, {32'h0, GOOD_HDR});
        @(negedge clk);
        drive_idle();
        repeat (3) @(negedge clk);
        checks++; if (ev4 !== 2'b01) begin errors++; $display("FAIL clr_valid got %b exp 01", ev4); end
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        checks++; if (p4 !== 32'd0) begin errors++; $display("FAIL clr_pass got %0d exp 0", p4); end
        checks++; if (f4 !== 32'd0 || u4 !== 32'd0) begin errors++; $display("FAIL clr_other got %0d %0d exp 0 0", f4, u4); end
        drive(2'b01, {32'h0, GOOD_HDR});
        @(negedge clk);
        drive_idle();
        repeat (4) @(negedge clk);
        checks++; if (p4 !== 32'd1) begin errors++; $display("FAIL clr_after_pass got %0d exp 1", p4); end
    endtask

    task automatic test_saturation();
        idle(20);
        clear_counters();
        for (int i = 0; i < 6; i++) begin
            drive(2'b01, {32'h0, GOOD_HDR});
            @(negedge clk);
        end
        idle(4);
        checks++; if (p3 !== 3'd6) begin errors++; $display("FAIL sat_preload got %0d exp 6", p3); end
        for (int i = 0; i < 3; i++) begin
            drive(2'b01, {32'h0, GOOD_HDR});
            @(negedge clk);
        end
        idle(5);
        checks++; if (p3 !== 3'd7) begin errors++; $display("FAIL sat_hold got %0d exp 7", p3); end
        checks++; if (f3 !== 3'd0) begin errors++; $display("FAIL sat_fail got %0d exp 0", f3); end
    endtask

    task automatic test_reset_midflight();
        idle(20);
        drive(2'b11, {UPD_A, GOOD_HDR});
        @(negedge clk);
        drive_idle();
        for (int k = 1; k <= 10; k++) begin
            checks++; if (ev4 !== 2'b00 || ev3 !== 2'b00 || ev16 !== 2'b00) begin
                errors++; $display("FAIL rst_mid_valid cyc %0d got %b %b %b exp 00", k, ev4, ev3, ev16);
            end
            if (k == 2) rst_n = 1'b0;
            if (k == 4) rst_n = 1'b1;
            @(negedge clk);
        end
        checks++; if (p4 !== 32'd0 || f4 !== 32'd0 || u4 !== 32'd0) begin errors++; $display("FAIL rst_mid_cnt got %0d %0d %0d exp 0 0 0", p4, f4, u4); end
        drive(2'b11, {UPD_A, GOOD_HDR});
        @(negedge clk);
        drive_idle();
        repeat (3) @(negedge clk);
        checks++; if (ev4 !== 2'b11) begin errors++; $display("FAIL rst_after_valid got %b exp 11", ev4); end
        checks++; if (ei4 !== {16'hB961, 1'b1}) begin errors++; $display("FAIL rst_after_data got %h exp %h", ei4, {16'hB961, 1'b1}); end
        @(negedge clk);
        checks++; if (p4 !== 32'd1 || u4 !== 32'd1) begin errors++; $display("FAIL rst_after_cnt got %0d %0d exp 1 1", p4, u4); end
    endtask

    initial begin
        test_reset();
        clear_counters();
        test_verify(GOOD_HDR, 1'b1, 32'd1, 32'd0);
        test_verify(BAD_HDR, 1'b0, 32'd1, 32'd1);
        test_update();
        test_back_to_back();
        test_cnt_clear();
        test_saturation();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
